// File: rtl/csa_sum_accumulator.sv
// Block accumulator downstream of the 4-operand 4-bit CSA.
// Sums COUNT results per block and presents total, mean and max.
module csa_sum_accumulator #(
  parameter int IN_W  = 6,
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [IN_W-1:0]  out_mean,
  output logic [IN_W-1:0]  out_max,
  output logic             out_overflow,
  output logic [4:0]       out_count
);

  localparam int CW = $clog2(COUNT);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t state, state_n;

  logic [ACC_W:0]  acc, acc_n, mean_w;
  logic [IN_W-1:0] mx, mx_n, v;
  logic [4:0]      cnt;
  logic            ovf, ovf_n;
  logic            accept, last, drain, flush;

  assign v         = IN_W'({in_cout, in_sum});
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_count = cnt;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;
  assign last   = (cnt == 5'(COUNT - 1));
  assign flush  = rst || clear;

  // Running sum/max/overflow including the value being accepted.
  always_comb begin
    acc_n  = acc + (ACC_W+1)'(v);
    ovf_n  = ovf | acc_n[ACC_W];
    mx_n   = (v > mx) ? v : mx;
    mean_w = acc_n >> CW;
  end

  // Next-state: fill the block, then hold until downstream takes it.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_n = last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset and clear both return to an empty block.
  always_ff @(posedge clk) begin
    if (flush) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Partial-block accumulator, max and accepted-count.
  always_ff @(posedge clk) begin
    if (flush || drain) begin
      acc <= '0;
      mx  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_n;
      mx  <= mx_n;
      cnt <= cnt + 5'd1;
      ovf <= ovf_n;
    end
  end

  // Result registers, loaded on the block's final accept.
  always_ff @(posedge clk) begin
    if (flush || drain) begin
      out_total    <= '0;
      out_mean     <= '0;
      out_max      <= '0;
      out_overflow <= 1'b0;
    end else if (accept && last) begin
      out_total    <= acc_n[ACC_W-1:0];
      out_mean     <= mean_w[IN_W-1:0];
      out_max      <= mx_n;
      out_overflow <= ovf_n;
    end
  end

endmodule

// File: tb/tb_csa_sum_accumulator.sv
// Directed bench for csa_sum_accumulator.
// Runs an ACC_W=8 and an ACC_W=7 instance on shared stimulus.
module tb_csa_sum_accumulator;

  logic       clk;
  logic       rst, clear, in_valid, out_ready;
  logic [4:0] in_sum;
  logic       in_cout;

  logic       ir8, ov8, of8;
  logic [7:0] tot8;
  logic [5:0] mean8, max8;
  logic [4:0] cnt8;

  logic       ir7, ov7, of7;
  logic [6:0] tot7;
  logic [5:0] mean7, max7;
  logic [4:0] cnt7;

  int n_chk  = 0;
  int n_fail = 0;

  csa_sum_accumulator #(.IN_W(6), .COUNT(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(ir8),
    .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(ov8), .out_ready(out_ready),
    .out_total(tot8), .out_mean(mean8), .out_max(max8),
    .out_overflow(of8), .out_count(cnt8)
  );

  csa_sum_accumulator #(.IN_W(6), .COUNT(4), .ACC_W(7)) dut7 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(ir7),
    .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(ov7), .out_ready(out_ready),
    .out_total(tot7), .out_mean(mean7), .out_max(max7),
    .out_overflow(of7), .out_count(cnt7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, c, iv;
    logic [5:0] v;
    logic       ordy;
    int         eov, eir, etot, emean, emax, eof, ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, c, iv, input logic [5:0] v,
                     input logic ordy, input int eov, eir, etot,
                     emean, emax, eof, ecnt);
    vec_t e;
    e.r = r; e.c = c; e.iv = iv; e.v = v; e.ordy = ordy;
    e.eov = eov; e.eir = eir; e.etot = etot; e.emean = emean;
    e.emax = emax; e.eof = eof; e.ecnt = ecnt;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, settle 1 ns past it.
  task automatic apply(input logic r, c, iv, input logic [5:0] v,
                       input logic ordy);
    rst = r; clear = c; in_valid = iv;
    {in_cout, in_sum} = v;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_sum = '0; in_cout = 1'b0; out_ready = 1'b0;

    //   r c iv  v  ordy  ov ir tot mean max of cnt
    add(1, 0, 0,  0, 0,   0, 1,  0,  0,  0, 0, 0);
    add(0, 0, 1, 10, 1,   0, 1,  0,  0,  0, 0, 1);
    add(0, 0, 1, 20, 1,   0, 1,  0,  0,  0, 0, 2);
    add(0, 0, 1, 22, 1,   0, 1,  0,  0,  0, 0, 3);
    add(0, 0, 1, 24, 1,   1, 0, 76, 19, 24, 0, 4);
    add(0, 0, 1, 63, 1,   0, 1,  0,  0,  0, 0, 0);
    add(0, 0, 1,  5, 1,   0, 1,  0,  0,  0, 0, 1);
    add(0, 0, 0,  7, 1,   0, 1,  0,  0,  0, 0, 1);
    add(0, 0, 1,  0, 1,   0, 1,  0,  0,  0, 0, 2);
    add(0, 0, 0,  7, 1,   0, 1,  0,  0,  0, 0, 2);
    add(0, 0, 1, 31, 1,   0, 1,  0,  0,  0, 0, 3);
    add(0, 0, 0,  7, 1,   0, 1,  0,  0,  0, 0, 3);
    add(0, 0, 1, 33, 1,   1, 0, 69, 17, 33, 0, 4);
    add(0, 0, 0,  0, 1,   0, 1,  0,  0,  0, 0, 0);
    add(0, 0, 1, 50, 1,   0, 1,  0,  0,  0, 0, 1);
    add(0, 0, 1, 50, 1,   0, 1,  0,  0,  0, 0, 2);
    add(0, 1, 1, 50, 1,   0, 1,  0,  0,  0, 0, 0);
    add(0, 0, 1,  1, 1,   0, 1,  0,  0,  0, 0, 1);
    add(0, 0, 1,  2, 1,   0, 1,  0,  0,  0, 0, 2);
    add(0, 0, 1,  3, 1,   0, 1,  0,  0,  0, 0, 3);
    add(0, 0, 1,  4, 1,   1, 0, 10,  2,  4, 0, 4);
    add(0, 0, 0,  0, 1,   0, 1,  0,  0,  0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].iv, tbl[i].v, tbl[i].ordy);
      chk($sformatf("r%0d out_valid", i), int'(ov8), tbl[i].eov);
      chk($sformatf("r%0d in_ready", i), int'(ir8), tbl[i].eir);
      chk($sformatf("r%0d out_total", i), int'(tot8), tbl[i].etot);
      chk($sformatf("r%0d out_mean", i), int'(mean8), tbl[i].emean);
      chk($sformatf("r%0d out_max", i), int'(max8), tbl[i].emax);
      chk($sformatf("r%0d out_overflow", i), int'(of8), tbl[i].eof);
      chk($sformatf("r%0d out_count", i), int'(cnt8), tbl[i].ecnt);
    end

    // Back-pressure on a 60x4 block; the ACC_W=7 copy overflows.
    for (int k = 0; k < 4; k++) apply(0, 0, 1, 6'd60, 0);
    chk("bp total", int'(tot8), 240);
    chk("bp mean", int'(mean8), 60);
    chk("bp max", int'(max8), 60);
    chk("bp ovf8", int'(of8), 0);
    chk("ovf total7", int'(tot7), 112);
    chk("ovf flag7", int'(of7), 1);
    chk("ovf mean7", int'(mean7), 60);
    for (int k = 0; k < 5; k++) begin
      apply(0, 0, (k == 2), 6'd5, 0);
      chk($sformatf("bp%0d valid", k), int'(ov8), 1);
      chk($sformatf("bp%0d in_ready", k), int'(ir8), 0);
      chk($sformatf("bp%0d total", k), int'(tot8), 240);
      chk($sformatf("bp%0d max", k), int'(max8), 60);
      chk($sformatf("bp%0d count", k), int'(cnt8), 4);
    end
    apply(0, 0, 0, 6'd0, 1);
    chk("bp drain valid", int'(ov8), 0);
    chk("bp drain count", int'(cnt8), 0);
    chk("bp drain ready", int'(ir8), 1);

    // Block after an overflowing block must not carry the flag.
    apply(0, 0, 1, 6'd1, 1);
    chk("nb first count", int'(cnt8), 1);
    for (int k = 0; k < 3; k++) apply(0, 0, 1, 6'd1, 1);
    chk("nb valid", int'(ov8), 1);
    chk("nb total8", int'(tot8), 4);
    chk("nb total7", int'(tot7), 4);
    chk("nb ovf7", int'(of7), 0);
    chk("nb mean", int'(mean8), 1);
    apply(0, 0, 0, 6'd0, 1);

    // Reset mid-block.
    apply(0, 0, 1, 6'd9, 0);
    apply(0, 0, 1, 6'd9, 0);
    chk("mid count", int'(cnt8), 2);
    apply(1, 0, 1, 6'd9, 0);
    chk("mid rst valid", int'(ov8), 0);
    chk("mid rst total", int'(tot8), 0);
    chk("mid rst count", int'(cnt8), 0);
    apply(0, 0, 0, 6'd0, 0);
    chk("mid rst ready", int'(ir8), 1);

    // Reset while holding a result.
    for (int k = 0; k < 4; k++) apply(0, 0, 1, 6'd15, 0);
    chk("hold total", int'(tot8), 60);
    chk("hold ready", int'(ir8), 0);
    apply(1, 0, 0, 6'd0, 0);
    chk("hold rst valid", int'(ov8), 0);
    chk("hold rst total", int'(tot8), 0);
    chk("hold rst count", int'(cnt8), 0);
    chk("hold rst max", int'(max8), 0);
    apply(0, 0, 0, 6'd0, 0);
    chk("hold rst ready", int'(ir8), 1);
    chk("hold rst valid7", int'(ov7), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
